pipe_ctrl: RTL

//  Central pipeline sequencer for the 5-stage MIPS core. Gathers hazard/stall sources and drives
//  the per-stage stall vector and the flush strobe into the pc/if_id/id_ex/ex_mem/mem_wb registers:
//  - load-use hazards seen by the decode stage;
//  - multi-cycle EX operations (mult/div/madd), timed by an internal counter;
//  - exception flush requests.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipe_ctrl_hazard_detect.sv | 27 ++
 rtl/pipe_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_BITS = 6;
  localparam int unsigned REG_ADDR_W = 5;

  // Stall vector bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb
  localparam logic [STALL_BITS-1:0] STALL_NONE     = 6'b000000;
  localparam logic [STALL_BITS-1:0] STALL_LOAD_USE = 6'b000111;
  localparam logic [STALL_BITS-1:0] STALL_EX_BUSY  = 6'b001111;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the decode operands and a load in EX.
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                  reg1_read,
  input  logic [REG_ADDR_W-1:0] reg1_addr,
  input  logic                  reg2_read,
  input  logic [REG_ADDR_W-1:0] reg2_addr,
  input  logic                  ex_is_load,
  input  logic                  ex_wreg,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  output logic                  load_use_c
);

  logic rs_match;
  logic rt_match;
  logic load_pending;

  // Register $0 is hardwired, so a load targeting it never creates a dependency.
  always_comb begin
    load_pending = ex_is_load && ex_wreg && (ex_wd != '0);
    rs_match     = reg1_read && (reg1_addr == ex_wd);
    rt_match     = reg2_read && (reg2_addr == ex_wd);
    load_use_c   = load_pending && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage stall vector, flush strobe, multi-cycle EX
// tracking and a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MC_CNT_W = 6,
  parameter int unsigned STALL_W  = 6,
  parameter int unsigned PERF_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_reg1_read_i,
  input  logic [REG_ADDR_W-1:0] id_reg1_addr_i,
  input  logic                  id_reg2_read_i,
  input  logic [REG_ADDR_W-1:0] id_reg2_addr_i,
  input  logic                  ex_wreg_i,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  input  logic                  ex_is_load_i,
  input  logic                  ex_mc_start_i,
  input  logic [MC_CNT_W-1:0]   ex_mc_cycles_i,
  input  logic                  flush_req_i,
  output logic [STALL_W-1:0]    stall_o,
  output logic                  flush_o,
  output logic                  ex_mc_busy_o,
  output logic                  ex_mc_last_o,
  output logic [PERF_W-1:0]     stall_cnt_o
);

  mc_state_e               state_q;
  mc_state_e               state_d;
  logic [MC_CNT_W-1:0]     cnt_q;
  logic [MC_CNT_W-1:0]     cnt_d;
  logic                    flush_q;
  logic [PERF_W-1:0]       stall_cnt_q;
  logic [STALL_BITS-1:0]   stall_c;
  logic                    busy_c;
  logic                    last_c;
  logic                    load_use_c;
  logic                    mc_long_c;

  pipe_ctrl_hazard_detect u_hazard_detect (
    .reg1_read  (id_reg1_read_i),
    .reg1_addr  (id_reg1_addr_i),
    .reg2_read  (id_reg2_read_i),
    .reg2_addr  (id_reg2_addr_i),
    .ex_is_load (ex_is_load_i),
    .ex_wreg    (ex_wreg_i),
    .ex_wd      (ex_wd_i),
    .load_use_c (load_use_c)
  );

  assign mc_long_c = (ex_mc_cycles_i >= MC_CNT_W'(2));

  // FSM state and down-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and stall priority: rst > flush > busy op > load-use.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = STALL_NONE;
    busy_c  = 1'b0;
    last_c  = 1'b0;
    if (rst || flush_q) begin
      state_d = MC_IDLE;
      cnt_d   = '0;
    end else if (state_q == MC_BUSY) begin
      busy_c = 1'b1;
      if (cnt_q != '0) begin
        stall_c = STALL_EX_BUSY;
        cnt_d   = cnt_q - MC_CNT_W'(1);
      end else begin
        last_c  = 1'b1;
        state_d = MC_IDLE;
      end
    end else if (ex_mc_start_i && mc_long_c) begin
      // First EX cycle counts toward N, so N-2 further stall cycles remain.
      stall_c = STALL_EX_BUSY;
      state_d = MC_BUSY;
      cnt_d   = ex_mc_cycles_i - MC_CNT_W'(2);
    end else begin
      last_c = ex_mc_start_i;
      if (load_use_c) begin
        stall_c = STALL_LOAD_USE;
      end
    end
  end

  // One-cycle-delayed flush strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_q <= 1'b0;
    end else begin
      flush_q <= flush_req_i;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if ((stall_c != STALL_NONE) && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + PERF_W'(1);
    end
  end

  assign stall_o      = STALL_W'(stall_c);
  assign flush_o      = flush_q;
  assign ex_mc_busy_o = busy_c;
  assign ex_mc_last_o = last_c;
  assign stall_cnt_o  = stall_cnt_q;

endmodule
